// File: rtl/dco_tune_dither.sv
// ----------------------------------------------------------------------------
// dco_tune_dither
//
// Front end of the DCO tracking-bank row/column coder. It takes an integer
// plus fractional tuning word from the loop filter over a valid/ready
// handshake. Large integer jumps are slew-limited to STEP units per clock.
// Once on target, the fractional part is dithered onto the integer word with
// a first-order sigma-delta modulator.
//
// Optional build macro:
//   DCO_MASH2_EN  - replace the first-order modulator with a MASH 1-1
//                   (second accumulator plus a delayed second-stage carry).
//
// Ports:
//   clk        in   DCO-domain clock (state updates on posedge)
//   rst        in   asynchronous reset, active high
//   tw_int     in   [WORD_W-1:0] target integer tuning word
//   tw_frac    in   [FRAC_W-1:0] target fractional tuning word
//   tw_valid   in   target word valid
//   tw_ready   out  block can accept a target (low while slewing)
//   dither_en  in   enable sigma-delta dithering of tw_frac
//   word_out   out  [WORD_W-1:0] word to the row/col coder
//   word_en    out  enable to the row/col coder
//   busy       out  high while slewing
// ----------------------------------------------------------------------------
module dco_tune_dither #(
    parameter int WORD_W   = 8,
    parameter int FRAC_W   = 4,
    parameter int STEP     = 4,
    parameter int RST_WORD = 128
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WORD_W-1:0] tw_int,
    input  logic [FRAC_W-1:0] tw_frac,
    input  logic              tw_valid,
    output logic              tw_ready,
    input  logic              dither_en,
    output logic [WORD_W-1:0] word_out,
    output logic              word_en,
    output logic              busy
);

    localparam logic [WORD_W-1:0] L_RST_WORD = WORD_W'(RST_WORD);
    localparam logic [WORD_W:0]   L_STEP_X   = (WORD_W+1)'(STEP);
    localparam logic [WORD_W-1:0] L_STEP     = WORD_W'(STEP);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SLEW  = 2'd1,
        TRACK = 2'd2
    } state_t;

    state_t              r_state;
    logic [WORD_W-1:0]   r_target_int;
    logic [FRAC_W-1:0]   r_target_frac;
    logic [FRAC_W-1:0]   r_acc;
    logic [WORD_W-1:0]   r_word;
    logic                r_word_en;
    logic                r_busy;
    logic                r_ready;

    // Handshake
    logic                w_accept;

    // Distance from the current word to the incoming target (accept edge)
    logic signed [WORD_W:0] w_diff_acc;
    logic        [WORD_W:0] w_abs_acc;
    logic                   w_acc_big;

    // Distance from the current word to the captured target (slewing)
    logic signed [WORD_W:0] w_diff_slew;
    logic        [WORD_W:0] w_abs_slew;
    logic                   w_slew_done;
    logic [WORD_W-1:0]      w_slew_next;

    // First modulator stage
    logic [FRAC_W:0]        w_sum1;
    logic                   w_c1;

    // Dithered word
    logic [WORD_W-1:0]      w_track_word;

`ifdef DCO_MASH2_EN
    logic [FRAC_W-1:0]      r_acc2;
    logic                   r_c2_d;
    logic [FRAC_W:0]        w_sum2;
    logic                   w_c2;
    logic signed [WORD_W+1:0] w_msum;
`else
    logic [WORD_W:0]        w_tsum;
`endif

    assign tw_ready = r_ready;
    assign word_out = r_word;
    assign word_en  = r_word_en;
    assign busy     = r_busy;

    assign w_accept = tw_valid & r_ready;

    // Signed difference at WORD_W+1 bits so a full-scale jump never overflows.
    assign w_diff_acc  = $signed({1'b0, tw_int}) - $signed({1'b0, r_word});
    assign w_abs_acc   = w_diff_acc[WORD_W] ? $unsigned(-w_diff_acc) : $unsigned(w_diff_acc);
    assign w_acc_big   = (w_abs_acc > L_STEP_X);

    assign w_diff_slew = $signed({1'b0, r_target_int}) - $signed({1'b0, r_word});
    assign w_abs_slew  = w_diff_slew[WORD_W] ? $unsigned(-w_diff_slew) : $unsigned(w_diff_slew);
    assign w_slew_done = (w_abs_slew <= L_STEP_X);

    always_comb begin
        w_slew_next = r_word;
        if (w_slew_done) begin
            w_slew_next = r_target_int;
        end else if (w_diff_slew[WORD_W]) begin
            w_slew_next = r_word - L_STEP;
        end else begin
            w_slew_next = r_word + L_STEP;
        end
    end

    assign w_sum1 = {1'b0, r_acc} + {1'b0, r_target_frac};
    assign w_c1   = w_sum1[FRAC_W];

`ifdef DCO_MASH2_EN
    // Second stage integrates the first-stage residue; its carry is
    // differentiated so the offset spans -1..+2 around the target.
    assign w_sum2 = {1'b0, r_acc2} + {1'b0, w_sum1[FRAC_W-1:0]};
    assign w_c2   = w_sum2[FRAC_W];
    assign w_msum = $signed({2'b00, r_target_int})
                  + $signed({{(WORD_W+1){1'b0}}, w_c1})
                  + $signed({{(WORD_W+1){1'b0}}, w_c2})
                  - $signed({{(WORD_W+1){1'b0}}, r_c2_d});

    always_comb begin
        w_track_word = w_msum[WORD_W-1:0];
        if (w_msum[WORD_W+1]) begin
            w_track_word = '0;
        end else if (w_msum[WORD_W]) begin
            w_track_word = '1;
        end
    end
`else
    assign w_tsum = {1'b0, r_target_int} + {{WORD_W{1'b0}}, w_c1};

    // Saturate at full scale instead of wrapping to zero.
    always_comb begin
        w_track_word = w_tsum[WORD_W-1:0];
        if (w_tsum[WORD_W]) begin
            w_track_word = '1;
        end
    end
`endif

    // Accept can only fire in IDLE/TRACK (ready is low in SLEW), and it takes
    // priority over that edge's dither update: word_out holds on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_target_int  <= L_RST_WORD;
            r_target_frac <= '0;
            r_acc         <= '0;
            r_word        <= L_RST_WORD;
            r_word_en     <= 1'b0;
            r_busy        <= 1'b0;
            r_ready       <= 1'b1;
`ifdef DCO_MASH2_EN
            r_acc2        <= '0;
            r_c2_d        <= 1'b0;
`endif
        end else if (w_accept) begin
            r_target_int  <= tw_int;
            r_target_frac <= tw_frac;
            r_acc         <= '0;
            r_word_en     <= 1'b1;
`ifdef DCO_MASH2_EN
            r_acc2        <= '0;
            r_c2_d        <= 1'b0;
`endif
            if (w_acc_big) begin
                r_state <= SLEW;
                r_busy  <= 1'b1;
                r_ready <= 1'b0;
            end else begin
                r_state <= TRACK;
                r_busy  <= 1'b0;
                r_ready <= 1'b1;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_word    <= L_RST_WORD;
                    r_word_en <= 1'b0;
                end
                SLEW: begin
                    r_word <= w_slew_next;
                    if (w_slew_done) begin
                        r_state <= TRACK;
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                    end
                end
                TRACK: begin
                    if (dither_en) begin
                        r_acc  <= w_sum1[FRAC_W-1:0];
                        r_word <= w_track_word;
`ifdef DCO_MASH2_EN
                        r_acc2 <= w_sum2[FRAC_W-1:0];
                        r_c2_d <= w_c2;
`endif
                    end else begin
                        r_acc  <= '0;
                        r_word <= r_target_int;
`ifdef DCO_MASH2_EN
                        r_acc2 <= '0;
                        r_c2_d <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule
